// File: rtl/tt_sweep_eval.sv
// -----------------------------------------------------------------------------
// tt_sweep_eval
// Loadable N_IN-input truth-table function with two ways to read it:
//   * a one-cycle registered single-vector evaluation port
//   * a sweep engine that walks all 2^N_IN input vectors in order, streams
//     each vector with its function value and counts the true minterms.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   tt_load    in   load tt_data into the table (accepted only when idle)
//   tt_data    in   new truth table, bit i = output for input vector i
//   start      in   request a sweep (accepted only when idle)
//   eval_en    in   single-vector evaluation request
//   eval_in    in   vector to evaluate
//   eval_out   out  registered function value for the last request
//   eval_valid out  eval_out was produced by a request on the previous edge
//   busy       out  sweep engine is in SWEEP or DONE
//   vec        out  current sweep vector (meaningful while s_valid)
//   s          out  function value for vec
//   s_valid    out  vec/s valid this cycle
//   ones_cnt   out  true minterms seen in the current/last sweep
//   done       out  one-cycle sweep-complete pulse
// -----------------------------------------------------------------------------
module tt_sweep_eval #(
    parameter int                    N_IN    = 4,
    parameter logic [(1<<N_IN)-1:0]  TT_INIT = 16'h7310
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tt_load,
    input  logic [(1<<N_IN)-1:0]    tt_data,
    input  logic                    start,
    input  logic                    eval_en,
    input  logic [N_IN-1:0]         eval_in,
    output logic                    eval_out,
    output logic                    eval_valid,
    output logic                    busy,
    output logic [N_IN-1:0]         vec,
    output logic                    s,
    output logic                    s_valid,
    output logic [N_IN:0]           ones_cnt,
    output logic                    done
);

    localparam int              DEPTH    = 1 << N_IN;
    localparam int              CNT_W    = N_IN + 1;
    localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};
    localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [DEPTH-1:0]     tt_q, tt_d;
    logic [N_IN-1:0]      vec_q, vec_d;
    logic [CNT_W-1:0]     ones_q, ones_d;
    logic                 eval_out_q, eval_out_d;
    logic                 eval_valid_q, eval_valid_d;
    logic                 s_cur;

    // Function value of the vector currently held in the sweep register.
    assign s_cur = tt_q[vec_q];

    // Sweep FSM next state, table load and minterm counting.
    always_comb begin
        state_d = state_q;
        tt_d    = tt_q;
        vec_d   = vec_q;
        ones_d  = ones_q;
        case (state_q)
            ST_IDLE: begin
                // A load and a start on the same edge are both taken, so the
                // sweep that follows reads the freshly loaded table.
                if (tt_load) begin
                    tt_d = tt_data;
                end else begin
                    tt_d = tt_q;
                end
                if (start) begin
                    state_d = ST_SWEEP;
                    vec_d   = '0;
                    ones_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SWEEP: begin
                ones_d = ones_q + CNT_W'(s_cur);
                // Leave on the last vector so vec never wraps.
                if (vec_q == VEC_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    vec_d = vec_q + VEC_ONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Single-vector evaluation path, independent of the sweep state.
    always_comb begin
        eval_valid_d = eval_en;
        if (eval_en) begin
            eval_out_d = tt_q[eval_in];
        end else begin
            eval_out_d = eval_out_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            tt_q         <= TT_INIT;
            vec_q        <= '0;
            ones_q       <= '0;
            eval_out_q   <= 1'b0;
            eval_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tt_q         <= tt_d;
            vec_q        <= vec_d;
            ones_q       <= ones_d;
            eval_out_q   <= eval_out_d;
            eval_valid_q <= eval_valid_d;
        end
    end

    // Outputs are decodes of registered state only.
    assign busy       = (state_q != ST_IDLE);
    assign s_valid    = (state_q == ST_SWEEP);
    assign done       = (state_q == ST_DONE);
    assign s          = s_valid & s_cur;
    assign vec        = vec_q;
    assign ones_cnt   = ones_q;
    assign eval_out   = eval_out_q;
    assign eval_valid = eval_valid_q;

endmodule

// File: doc/tt_sweep_eval.md
Name: tt_sweep_eval

Overview:
- Parametrised, clocked successor to the team's fixed 4-input combinational logic-function blocks.
- Holds an N-input boolean function as a loadable truth table.
- Offers a one-cycle registered single-vector evaluation port.
- Offers an autonomous sweep engine that steps through all 2^N input vectors, streams each vector with its output, and counts the true minterms.
- Used as a self-checking function generator beside exhaustive-stimulus benches and in lab datapaths.

Parameters:
- N_IN, 4, number of function inputs; legal range 1..8.
- TT_INIT, 16'h7310, reset value of the truth table (2^N_IN bits). Bit i is the output for input vector i.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- tt_load  in  1  load truth table this cycle
- tt_data  in  2^N_IN  new truth table
- start  in  1  request exhaustive sweep
- eval_en  in  1  single-vector evaluation request
- eval_in  in  N_IN  vector to evaluate
- eval_out  out  1  registered function value
- eval_valid  out  1  eval_out valid
- busy  out  1  sweep engine not idle
- vec  out  N_IN  current sweep vector
- s  out  1  function value for vec
- s_valid  out  1  vec/s valid this cycle
- ones_cnt  out  N_IN+1  number of true minterms seen in the current/last sweep
- done  out  1  one-cycle sweep-complete pulse

Behaviour:
- Reset (async, any state, including mid-sweep):
  - tt_reg=TT_INIT, state=IDLE.
  - vec=0, s_valid=0, ones_cnt=0, done=0, busy=0, eval_out=0, eval_valid=0.
  - Sweep in progress is abandoned; no done pulse.
- Truth table load:
  - tt_load=1 in IDLE writes tt_reg<=tt_data at that edge.
  - tt_load is ignored in SWEEP and DONE.
- Single evaluation:
  - Independent of the sweep FSM; usable in any state.
  - eval_en=1 at edge t → at t+1 eval_out=tt_reg[eval_in] (tt_reg value before edge t), eval_valid=1.
  - eval_en=0 → eval_valid=0 next cycle; eval_out holds its value.
- FSM states:
  - IDLE: busy=0. start=1 → SWEEP; vec<=0, ones_cnt<=0.
  - SWEEP: busy=1, s_valid=1, s=tt_reg[vec] (combinational from registers).
    - Each edge: ones_cnt<=ones_cnt+s.
    - If vec==2^N_IN-1 → DONE. Otherwise vec<=vec+1.
  - DONE: busy=1, s_valid=0, done=1 for exactly this one cycle; → IDLE.
- Simultaneous tt_load and start in IDLE:
  - Both are accepted.
  - The sweep evaluates the newly loaded table.
- start in SWEEP/DONE: ignored, not queued.
- Timing for start accepted at edge t:
  - s_valid high for cycles t+1..t+2^N_IN.
  - done at t+2^N_IN+1.
  - Next start accepted at t+2^N_IN+2.
- Outputs after a sweep:
  - ones_cnt holds its final value until the next accepted start or reset.
  - vec holds 2^N_IN-1 after the sweep, but is meaningful only when s_valid=1.
- Width rules:
  - ones_cnt is N_IN+1 bits, so an all-ones table (2^N_IN) does not overflow.
  - vec increments cleanly; no wrap occurs because the FSM exits on the final vector.

Test Plan:
- Reset, then start with N_IN=4 and default table → s_valid for 16 cycles; s=1 exactly at vec 4,8,9,12,13,14; done pulses 17 cycles after start; ones_cnt=6.
- tt_load with tt_data=16'hFFFF and start in the same cycle → sweep with all s=1; ones_cnt=16 (5'b10000, no overflow); then load 16'h0000 and sweep → ones_cnt=0.
- eval_en with eval_in=4'b1101 on the default table → eval_out=1, eval_valid=1 next cycle; eval_in=4'b0011 → eval_out=0. Repeat mid-sweep with identical results.
- During a sweep, pulse tt_load=1 (tt_data=0) and start=1 at vec=5 → table unchanged, sweep not restarted, final ones_cnt=6.
- Assert reset at vec=9 of a sweep → all outputs 0 immediately (asynchronous), tt_reg=16'h7310, no done. Start after release → full 16-vector sweep.
- Instantiate with N_IN=2, TT_INIT=4'b1000 → 4 valid cycles, s=1 only at vec=3, ones_cnt=1, done at start+5.
